// File: rtl/regset_pkg.sv
// Shared types and helpers for the regset_bram register file.
// Holds the CLEAR/RUN state encoding and the even-parity helper used on write and read.
package regset_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Parity helper takes a fixed-width vector; callers zero-extend, which leaves XOR unchanged.
  localparam int PAR_MAXW = 1040;

  function automatic logic even_parity(input logic [PAR_MAXW-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/regset_ram.sv
// Storage for regset_bram: one write port, two synchronous read ports.
// Latency: 1 cycle, read-old on same-address collision. No backpressure; no reset.
module regset_ram #(
  parameter int W     = 33,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  q1,
  output logic [W-1:0]  q2
);

  // One copy per read port so each maps onto a simple dual-port block RAM.
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] mem2 [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem1[wa] <= wd;
    q1 <= mem1[ra1];
  end

  always_ff @(posedge clk) begin
    if (we) mem2[wa] <= wd;
    q2 <= mem2[ra2];
  end

endmodule

// File: rtl/regset_bram.sv
// Two-read/one-write register file that self-clears on reset; address 0 reads as zero.
// Latency: 1 cycle read, optional write-first bypass. No backpressure; ready=0 while clearing.
// Optional parity storage and checking is enabled by REGSET_PARITY_EN.
module regset_bram
  import regset_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             ready,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             wg,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rg1,
  output logic             rg2
`ifdef REGSET_PARITY_EN
  ,
  output logic             perr
`endif
);

  // Entry layout: data in [WIDTH-1:0], grubby tag at [WIDTH], parity (if present) above it.
`ifdef REGSET_PARITY_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH + 1;
`endif

  state_e        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) state <= RUN;
    end
  end

  assign ready = (state == RUN);

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [EW-1:0] mem_wd;
  logic [EW-1:0] q1, q2;

  // An all-zero entry already carries correct even parity, so the clear pattern is just '0.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt;
    mem_wd = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (we && (wa != '0)) begin
      mem_we = 1'b1;
      mem_wa = wa;
`ifdef REGSET_PARITY_EN
      mem_wd = {even_parity(PAR_MAXW'({wg, wd})), wg, wd};
`else
      mem_wd = {wg, wd};
`endif
    end
  end

  regset_ram #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .we  (mem_we),
    .wa  (mem_wa),
    .wd  (mem_wd),
    .ra1 (ra1),
    .ra2 (ra2),
    .q1  (q1),
    .q2  (q2)
  );

  // Masking and forwarding decisions are registered alongside the RAM read so the
  // outputs stay at 1-cycle latency and can be forced to zero by the async reset.
  logic             zero1_q, zero2_q;
  logic             byp1_q, byp2_q;
  logic [WIDTH-1:0] fwd_d_q;
  logic             fwd_g_q;
  logic             wr_run;

  assign wr_run = (BYPASS != 0) && (state == RUN) && we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      fwd_d_q <= '0;
      fwd_g_q <= 1'b0;
    end else begin
      zero1_q <= (state != RUN) || (ra1 == '0);
      zero2_q <= (state != RUN) || (ra2 == '0);
      byp1_q  <= wr_run && (wa == ra1);
      byp2_q  <= wr_run && (wa == ra2);
      fwd_d_q <= wd;
      fwd_g_q <= wg;
    end
  end

  always_comb begin
    rd1 = q1[WIDTH-1:0];
    rg1 = q1[WIDTH];
    rd2 = q2[WIDTH-1:0];
    rg2 = q2[WIDTH];
    if (byp1_q) begin
      rd1 = fwd_d_q;
      rg1 = fwd_g_q;
    end
    if (byp2_q) begin
      rd2 = fwd_d_q;
      rg2 = fwd_g_q;
    end
    if (zero1_q) begin
      rd1 = '0;
      rg1 = 1'b0;
    end
    if (zero2_q) begin
      rd2 = '0;
      rg2 = 1'b0;
    end
  end

`ifdef REGSET_PARITY_EN
  // A healthy stored entry XORs to zero across data, tag and parity bit.
  logic bad1, bad2;
  assign bad1 = !zero1_q && !byp1_q && even_parity(PAR_MAXW'(q1));
  assign bad2 = !zero2_q && !byp2_q && even_parity(PAR_MAXW'(q2));
  assign perr = bad1 || bad2;
`endif

endmodule

// File: doc/regset_bram.md
REGSET_BRAM -- requirements
Module: regset_bram

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 64: entry count, power of two, 2..1024; localparam AW = log2(DEPTH).
REQ-003 SHALL have parameter BYPASS, default 1: 1 = write-first forwarding on same-address read, 0 = read-old.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 ready  out  1  high when clear sequence is done and ports are usable.
REQ-007 we  in  1  write enable.
REQ-008 wa  in  AW  write address.
REQ-009 wd  in  WIDTH  write data.
REQ-010 wg  in  1  grubby tag written with wd.
REQ-011 ra1, ra2  in  AW each  read addresses.
REQ-012 rd1, rd2  out  WIDTH each  registered read data.
REQ-013 rg1, rg2  out  1 each  registered grubby tag of the read entry.
REQ-014 perr  out  1  parity error on either read port; present only with REGSET_PARITY_EN.

Function
REQ-015 SHALL implement FSM states CLEAR, RUN; CLEAR on reset; CLEAR -> RUN after writing entry DEPTH-1.
REQ-016 In CLEAR, counter SHALL start at 0, write data 0, grubby 0 (and correct parity) to entry counter each cycle, increment by 1; clear lasts exactly DEPTH cycles.
REQ-017 ready SHALL be 0 in CLEAR, 1 in RUN; first ready=1 cycle is DEPTH cycles after rstn deasserts.
REQ-018 External writes (we) during CLEAR SHALL be ignored; reads during CLEAR return don't-care data but SHALL not corrupt state.
REQ-019 In RUN, we=1 with wa!=0 SHALL write wd/wg at that edge; writes to address 0 SHALL be ignored.
REQ-020 Read latency SHALL be 1 cycle: rd/rg at edge N+1 reflect address sampled at edge N.
REQ-021 Address 0 SHALL always read data 0, grubby 0, regardless of memory contents.
REQ-022 Same-cycle we=1, wa==ra!=0 in RUN: BYPASS=1 SHALL return the new wd/wg; BYPASS=0 SHALL return old contents.
REQ-023 ra1==ra2 SHALL return identical data on both ports.
REQ-024 Writes to DEPTH-1 SHALL not alias any other address; no wrap beyond DEPTH.

Reset
REQ-025 Asserting rstn low SHALL immediately force state CLEAR, counter 0, ready 0, rd1/rd2 0, rg1/rg2 0, perr 0.
REQ-026 Reset mid-CLEAR or mid-RUN SHALL restart the full DEPTH-cycle clear; memory array itself has no reset.

Configuration
REQ-027 Macro REGSET_PARITY_EN defined: each entry SHALL store an extra even-parity bit over {wd,wg}; reads SHALL recompute it; perr SHALL be 1 in the cycle rd/rg are presented if either port (address !=0) mismatches.
REQ-028 Macro undefined: no parity storage, no perr port; all other behaviour identical.

Structure
REQ-029 Package regset_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the parity function.
REQ-030 Storage SHALL be sub-module regset_ram: one write port, two synchronous read ports (duplicated 1R1W arrays permitted), no reset, inferable as BRAM.
REQ-031 FSM, clear counter, address-0 masking, bypass muxing and parity check SHALL sit in regset_bram.

Verification
REQ-032 Reset release, DEPTH=64 -> ready=0 for 64 cycles, then 1; all 64 reads return 0, rg 0.
REQ-033 RUN: write wa=5 wd=0xDEADBEEF wg=1; next cycle ra1=5 -> rd1=0xDEADBEEF, rg1=1 one cycle later.
REQ-034 write wa=0 wd=0xFFFFFFFF; read ra1=ra2=0 -> rd1=rd2=0.
REQ-035 same cycle we wa=7 wd=0x12345678, ra2=7 (entry held 0x1) -> BYPASS=1: rd2=0x12345678; BYPASS=0: rd2=0x1.
REQ-036 rstn low at clear count 30, then released -> ready returns after 64 further cycles; we during CLEAR with wa=9 wd=0xAA leaves entry 9 = 0.
REQ-037 REGSET_PARITY_EN: force-flip one stored bit of entry 3, read ra1=3 -> perr=1 with rd1; read of entry 0 -> perr=0.
